comparator_pipe: RTL
====================

COMPARATOR_PIPE -- requirements
Module: comparator_pipe

Interface
REQ-001 Parameter WIDTH, default 64, operand width in bits (legal 8..64).
REQ-002 Parameter TAG_W, default 5, width of the pass-through tag (e.g. destination register index).
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  operand set presented.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 a, b  input  WIDTH each  operands.
REQ-009 op  input  3  compare operation (EQ, NE, LT, GE, LTU, GEU).
REQ-010 tag_in  input  TAG_W  opaque tag carried with the operation.
REQ-011 flush  input  1  discard all in-flight operations.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts result this cycle.
REQ-014 result  output  1  outcome of op.
REQ-015 eq, lt, ltu  output  1 each  raw flags: a==b, signed a<b, unsigned a<b.
REQ-016 tag_out  output  TAG_W  tag of the presented result.

Function
REQ-017 Two register stages: S1 latches a-b (WIDTH+1 bits incl. borrow), operand sign bits, op, tag; S2 latches eq/lt/ltu/result, op, tag.
REQ-018 Latency exactly 2 cycles from accepted input (in_valid & in_ready) to out_valid with no backpressure; throughput 1 op/cycle.
REQ-019 eq = (a-b == 0); ltu = borrow out of a-b; lt = (a_sign & ~b_sign) | (~(a_sign ^ b_sign) & diff_sign).
REQ-020 result: EQ->eq, NE->~eq, LT->lt, GE->~lt, LTU->ltu, GEU->~ltu; reserved op codes give result=0, flags still valid.
REQ-021 Stage advance: S2 loads when S2 empty or out_ready; S1 loads when S1 empty or S1 advances into S2; in_ready = S1 empty or S1 advancing.
REQ-022 While out_valid & ~out_ready, result, flags, tag_out SHALL hold stable.
REQ-023 Simultaneous input accept and output drain in one cycle with both stages full SHALL lose no operation and duplicate none.
REQ-024 flush clears both stage valid bits next edge; an input presented in the flush cycle is dropped; in_ready is 0 during flush.
REQ-025 Data registers update only on load; no outputs other than out_valid/in_ready are required to be zero when out_valid=0.
REQ-026 Boundaries: most-negative vs most-positive (signed overflow of a-b) SHALL produce correct lt; a==b of any value gives eq=1, lt=0, ltu=0.

Reset
REQ-027 Reset clears S1/S2 valid bits immediately (asynchronously): out_valid=0, in_ready=1 while reset deasserted and no flush.
REQ-028 Reset clears result, eq, lt, ltu, tag_out to 0.
REQ-029 Reset asserted mid-operation discards all in-flight operations; first accepted op after release completes 2 cycles later.

Structure
REQ-030 Op encodings (EQ=0, NE=1, LT=2, GE=3, LTU=4, GEU=5) and WIDTH default SHALL live in shared package cmp_pkg.
REQ-031 Flag derivation from diff sign, borrow and operand signs SHALL be one combinational sub-module comparator_flags (parametrised WIDTH), instantiated between S1 and S2.

Verification
REQ-032 WIDTH=64, LT, a=0x8000_0000_0000_0000, b=0x7FFF_FFFF_FFFF_FFFF, out_ready=1 -> 2 cycles later result=1, lt=1, ltu=0, eq=0.
REQ-033 LTU/GEU back-to-back a=1,b=0xFFFF_FFFF_FFFF_FFFF then a=5,b=5 -> consecutive cycles result 1 then GEU 1 with eq=1, tags preserved in order.
REQ-034 Stream 4 ops, hold out_ready=0 for 3 cycles -> in_ready drops after 2 accepted, outputs stable, all 4 results delivered in order after release.
REQ-035 flush with both stages full plus input in flush cycle -> out_valid=0 next cycle, no dropped op ever appears.
REQ-036 Assert reset mid-stream -> out_valid=0 and outputs 0 without clock edge; post-release op completes in 2 cycles.
REQ-037 WIDTH=8 exhaustive a,b in -128..127 all six ops vs reference model -> zero errors.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared compare-unit definitions.
// Op encodings, default widths and the op-to-result select.
package cmp_pkg;

    localparam int CMP_WIDTH = 64;
    localparam int CMP_TAG_W = 5;

    typedef enum logic [2:0] {
        OP_EQ  = 3'd0,
        OP_NE  = 3'd1,
        OP_LT  = 3'd2,
        OP_GE  = 3'd3,
        OP_LTU = 3'd4,
        OP_GEU = 3'd5
    } cmp_op_e;

    typedef struct packed {
        logic eq;
        logic lt;
        logic ltu;
    } cmp_flags_t;

    // Reserved encodings (6, 7) resolve to 0.
    function automatic logic op_result(
        input logic [2:0] op,
        input cmp_flags_t f
    );
        logic r;
        r = 1'b0;
        case (op)
            OP_EQ:   r = f.eq;
            OP_NE:   r = ~f.eq;
            OP_LT:   r = f.lt;
            OP_GE:   r = ~f.lt;
            OP_LTU:  r = f.ltu;
            OP_GEU:  r = ~f.ltu;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/comparator_flags.sv
// Compare flags from a registered a-b.
// Ports: diff (WIDTH+1, msb = borrow), a_sign, b_sign -> flags {eq, lt, ltu}.
module comparator_flags
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH
) (
    input  logic [WIDTH:0] diff,
    input  logic           a_sign,
    input  logic           b_sign,
    output cmp_flags_t     flags
);

    logic diff_sign;

    assign diff_sign = diff[WIDTH-1];

    assign flags.eq  = (diff[WIDTH-1:0] == '0);
    assign flags.ltu = diff[WIDTH];
    // Differing signs decide directly; equal signs cannot overflow.
    assign flags.lt  = (a_sign & ~b_sign)
                     | (~(a_sign ^ b_sign) & diff_sign);

endmodule

// File: rtl/comparator_pipe.sv
// Two-stage pipelined integer comparator with valid/ready flow.
// Ports: clk, reset; in_valid/in_ready, a, b, op, tag_in, flush;
//        out_valid/out_ready, result, eq, lt, ltu, tag_out.
module comparator_pipe
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH,
    parameter int TAG_W = CMP_TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             result,
    output logic             eq,
    output logic             lt,
    output logic             ltu,
    output logic [TAG_W-1:0] tag_out
);

    typedef struct packed {
        logic [WIDTH:0]   diff;
        logic             a_sign;
        logic             b_sign;
        logic [2:0]       op;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        cmp_flags_t       flags;
        logic             result;
        logic [2:0]       op;
        logic [TAG_W-1:0] tag;
    } s2_t;

    s1_t        s1_q;
    s1_t        s1_d;
    s2_t        s2_q;
    s2_t        s2_d;
    logic       s1_valid;
    logic       s2_valid;
    logic       s2_load;
    logic       s1_adv;
    logic       s1_load;
    logic       accept;
    cmp_flags_t flags;
    logic       s2_op_unused;

    assign s2_load  = ~s2_valid | out_ready;
    assign s1_adv   = s1_valid & s2_load;
    assign s1_load  = ~s1_valid | s1_adv;
    assign in_ready = ~flush & s1_load;
    assign accept   = in_valid & in_ready;

    always_comb begin
        s1_d        = '0;
        s1_d.diff   = {1'b0, a} - {1'b0, b};
        s1_d.a_sign = a[WIDTH-1];
        s1_d.b_sign = b[WIDTH-1];
        s1_d.op     = op;
        s1_d.tag    = tag_in;
    end

    comparator_flags #(
        .WIDTH (WIDTH)
    ) u_flags (
        .diff   (s1_q.diff),
        .a_sign (s1_q.a_sign),
        .b_sign (s1_q.b_sign),
        .flags  (flags)
    );

    always_comb begin
        s2_d        = '0;
        s2_d.flags  = flags;
        s2_d.result = op_result(s1_q.op, flags);
        s2_d.op     = s1_q.op;
        s2_d.tag    = s1_q.tag;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_load) s2_valid <= s1_valid;
            if (s1_load) s1_valid <= in_valid;
            if (accept)  s1_q     <= s1_d;
            if (s1_adv)  s2_q     <= s2_d;
        end
    end

    // Latched op is kept for debug visibility only.
    assign s2_op_unused = ^s2_q.op;

    assign out_valid = s2_valid;
    assign result    = s2_q.result;
    assign eq        = s2_q.flags.eq;
    assign lt        = s2_q.flags.lt;
    assign ltu       = s2_q.flags.ltu;
    assign tag_out   = s2_q.tag;

endmodule
